// File: rtl/board_state_writer_pkg.sv
// Shared tile/result encodings, FSM states and the win-line table for the tic-tac-toe board bus.
package board_state_writer_pkg;

    localparam logic [1:0] TILE_EMPTY = 2'b00;
    localparam logic [1:0] TILE_BLUE  = 2'b10;
    localparam logic [1:0] TILE_RED   = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_BLUE = 2'b10;
    localparam logic [1:0] WIN_RED  = 2'b11;
    localparam logic [1:0] WIN_DRAW = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_EVAL  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int unsigned NUM_LINES = 8;

    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] tile_code(input logic [17:0] board, input int unsigned tile);
        return board[2*tile +: 2];
    endfunction

endpackage

// File: rtl/board_state_writer_line_check.sv
// Combinational three-in-a-row detector for one colour; reusable by move-hint logic.
module ttt_line_check
    import board_state_writer_pkg::*;
(
    input  logic [17:0] board,
    input  logic        colour_red,
    output logic        line_hit
);

    logic [1:0] want;
    logic       all_match;

    always_comb begin
        want      = colour_red ? TILE_RED : TILE_BLUE;
        line_hit  = 1'b0;
        all_match = 1'b0;
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
            all_match = 1'b1;
            for (int unsigned k = 0; k < 3; k++) begin
                if (tile_code(board, 32'(WIN_LINES[l][k])) != want) begin
                    all_match = 1'b0;
                end
            end
            if (all_match) begin
                line_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_state_writer.sv
// Authoritative tic-tac-toe board register: accepts moves, enforces turn order, and detects win/draw.
module board_state_writer
    import board_state_writer_pkg::*;
#(
    parameter bit          RED_FIRST = 1'b0,
    parameter int unsigned NUM_TILES = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_tile,
    output logic        move_ready,
    output logic        move_ack,
    output logic        move_reject,
    output logic [17:0] boardArr,
    output logic        turn_red,
    output logic [3:0]  move_count,
    output logic [1:0]  winner,
    output logic        game_over
);

    state_t      state;
    logic [3:0]  cap_tile;
    int unsigned tile_idx;
    logic [1:0]  cap_code;
    logic        tile_ok;
    logic        line_hit;

    ttt_line_check u_line_check (
        .board      (boardArr),
        .colour_red (turn_red),
        .line_hit   (line_hit)
    );

    // Occupancy is only looked up for in-range tiles so the board is never indexed past bit 17.
    always_comb begin
        tile_idx = 32'(cap_tile);
        cap_code = TILE_EMPTY;
        tile_ok  = 1'b0;
        if (tile_idx < NUM_TILES) begin
            cap_code = tile_code(boardArr, tile_idx);
            tile_ok  = !cap_code[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cap_tile    <= '0;
            boardArr    <= {9{TILE_EMPTY}};
            turn_red    <= RED_FIRST;
            move_count  <= '0;
            winner      <= WIN_NONE;
            game_over   <= 1'b0;
            move_ready  <= 1'b1;
            move_ack    <= 1'b0;
            move_reject <= 1'b0;
        end else begin
            move_ack    <= 1'b0;
            move_reject <= 1'b0;
            if (new_game) begin
                state      <= ST_IDLE;
                cap_tile   <= '0;
                boardArr   <= {9{TILE_EMPTY}};
                turn_red   <= RED_FIRST;
                move_count <= '0;
                winner     <= WIN_NONE;
                game_over  <= 1'b0;
                move_ready <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (move_valid && move_ready) begin
                            cap_tile   <= move_tile;
                            move_ready <= 1'b0;
                            state      <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        if (tile_ok) begin
                            boardArr[2*tile_idx +: 2] <= turn_red ? TILE_RED : TILE_BLUE;
                            move_count <= move_count + 4'd1;
                            move_ack   <= 1'b1;
                            state      <= ST_EVAL;
                        end else begin
                            move_reject <= 1'b1;
                            move_ready  <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_EVAL: begin
                        // turn_red still names the mover here; it only toggles if play continues.
                        move_ready <= 1'b1;
                        if (line_hit) begin
                            winner    <= turn_red ? WIN_RED : WIN_BLUE;
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else if (move_count == 4'(NUM_TILES)) begin
                            winner    <= WIN_DRAW;
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            turn_red <= !turn_red;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_OVER: begin
                        if (move_valid && move_ready) begin
                            move_reject <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
